// File: rtl/bitserial_logic_unit.sv
//==============================================================================
// bitserial_logic_unit : WIDTH-bit 2-input logic function, evaluated LSB first
// one bit per clock. Optional parity output under BITSERIAL_LOGIC_PARITY_EN.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module bitserial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef BITSERIAL_LOGIC_PARITY_EN
    ,output logic            parity
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               par_acc_q, par_acc_d;
    logic               parity_q, parity_d;
    logic               armed_q, armed_d;
    logic               w_bit;
    logic               w_accept;

    always_comb begin
        w_bit = 1'b0;
        case (op_q)
            3'b000:  w_bit =   a_sh_q[0] & b_sh_q[0];
            3'b001:  w_bit =   a_sh_q[0] | b_sh_q[0];
            3'b010:  w_bit = ~(a_sh_q[0] & b_sh_q[0]);
            3'b011:  w_bit = ~(a_sh_q[0] | b_sh_q[0]);
            3'b100:  w_bit =   a_sh_q[0] ^ b_sh_q[0];
            3'b101:  w_bit = ~(a_sh_q[0] ^ b_sh_q[0]);
            3'b110:  w_bit =  ~a_sh_q[0];
            default: w_bit =   a_sh_q[0];
        endcase
    end

    // armed_q blocks acceptance on the first edge after reset release
    assign w_accept = start && armed_q && (state_q != RUN);

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        par_acc_d = par_acc_q;
        parity_d  = parity_q;
        armed_d   = 1'b1;
        case (state_q)
            IDLE, DONE: begin
                if (w_accept) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    op_d      = op;
                    acc_d     = '0;
                    cnt_d     = '0;
                    par_acc_d = 1'b0;
                    state_d   = RUN;
                end else begin
                    state_d   = IDLE;
                end
            end
            RUN: begin
                acc_d     = {w_bit, acc_q[WIDTH-1:1]};
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                par_acc_d = par_acc_q ^ w_bit;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    parity_d = par_acc_d;
                    state_d  = DONE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            par_acc_q <= 1'b0;
            parity_q  <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            par_acc_q <= par_acc_d;
            parity_q  <= parity_d;
            armed_q   <= armed_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign zero   = zero_q;

`ifdef BITSERIAL_LOGIC_PARITY_EN
    assign parity = parity_q;
`else
    logic w_parity_unused;
    assign w_parity_unused = ^{par_acc_q, parity_q};
`endif

endmodule

`default_nettype wire
